multi_phase_sequencer: RTL

Parametrised N-phase instruction sequencer for the multicycle datapath. It generalises the fixed five-phase generator to NUM_PHASES phases and adds stall, restart (abort) and a completed-instruction counter. It drives one-hot phase enables to fetch/decode/execute/memory/writeback control and reports a binary phase index plus a completion pulse to the control unit.

---
 rtl/multi_phase_sequencer.sv | 73 +++++++
 1 files changed

// File: rtl/multi_phase_sequencer.sv
// multi_phase_sequencer: N-phase instruction sequencer with stall, restart
// and a completed-instruction counter. Phase enables are a one-hot decode of
// the phase register; instr_done flags the cycles in which the counter bumps.
module multi_phase_sequencer #(
  parameter  int unsigned NUM_PHASES = 5,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stall,
  input  logic                  restart,
  output logic [NUM_PHASES-1:0] Phases,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [IDX_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cur_legal;
  logic             at_last;

  // Next phase and counter: stall beats restart, restart beats normal advance.
  always_comb begin
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    cur_legal = ({1'b0, cur_q} < (IDX_W + 1)'(NUM_PHASES));
    at_last   = (cur_q == LAST_IDX);
    if (!cur_legal) begin
      // spare encodings fall back to phase 0
      cur_d = '0;
    end else if (!stall) begin
      if (restart) begin
        cur_d = '0;
      end else if (at_last) begin
        cur_d = '0;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cur_d = cur_q + IDX_W'(1);
      end
    end
  end

  // Completion pulse: high exactly when the counter increments at this edge.
  always_comb begin
    instr_done = at_last & cur_legal & ~stall & ~restart & ~RST;
  end

  // One-hot phase decode and binary index of the phase register.
  always_comb begin
    Phases = '0;
    for (int unsigned k = 0; k < NUM_PHASES; k++) begin
      Phases[k] = (cur_q == IDX_W'(k));
    end
    phase_idx   = cur_q;
    instr_count = cnt_q;
  end

  // Phase and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
